exec_int_sched: RTL

Issue and writeback scheduler for the integer execute stage. Accepts decoded integer instructions from decode over a valid/ready handshake and classifies each one as ALU, multiply or divide. It pulses the issue strobe of the integer datapath or the start strobe of the iterative divider, stalls decode while a multi-cycle operation would collide, and tags every result with its destination register on one in-order writeback port.

---
 rtl/exec_int_sched_pkg.sv | 41 ++++
 rtl/exec_int_tag_pipe.sv | 59 +++++
 rtl/exec_int_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/exec_int_sched_pkg.sv
// Shared definitions for the integer execute scheduler: opcodes, instruction
// classes, FSM states, tag layout and the classification helper used by decode.
package exec_int_sched_pkg;

    localparam int DIV_TIMEOUT_DEFAULT = 80;

    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MUL,
        CLS_DIV
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_GAP,
        ST_DIV_RUN
    } sched_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_mul;
    } int_tag_t;

    // Illegal encodings fall through to ALU so the datapath raises the exception.
    function automatic instr_class_e classify(input logic [4:0] opcode,
                                              input logic [2:0] funct3,
                                              input logic [6:0] funct7);
        instr_class_e cls;
        cls = CLS_ALU;
        if (((opcode == OPC_OP) || (opcode == OPC_OP_32)) && (funct7 == FUNCT7_MULDIV)) begin
            cls = funct3[2] ? CLS_DIV : CLS_MUL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/exec_int_tag_pipe.sv
// Two-stage destination tag pipe for the integer datapath: ALU tags exit from
// stage 0 after one cycle, MUL tags move on to stage 1 and exit after two.
module exec_int_tag_pipe
    import exec_int_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push_valid,
    input  logic [4:0] push_rd,
    input  logic       push_is_mul,
    input  logic       pop,
    output logic       pop_valid,
    output logic [4:0] pop_rd,
    output logic       any_valid
);

    int_tag_t stage0_q, stage0_d;
    int_tag_t stage1_q, stage1_d;
    int_tag_t exit_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage0_q <= '0;
            stage1_q <= '0;
        end else begin
            stage0_q <= stage0_d;
            stage1_q <= stage1_d;
        end
    end

    always_comb begin
        stage0_d = '0;
        stage1_d = '0;
        if (!flush) begin
            stage0_d.valid  = push_valid;
            stage0_d.rd     = push_rd;
            stage0_d.is_mul = push_is_mul;
            if (stage0_q.valid && stage0_q.is_mul) begin
                stage1_d = stage0_q;
            end
        end
    end

    // The multiply gap keeps stage 0 from holding an ALU tag while stage 1 is full.
    always_comb begin
        exit_tag = '0;
        if (stage1_q.valid) begin
            exit_tag = stage1_q;
        end else if (stage0_q.valid && !stage0_q.is_mul) begin
            exit_tag = stage0_q;
        end
    end

    assign pop_valid = exit_tag.valid && pop;
    assign pop_rd    = pop_valid ? exit_tag.rd : 5'd0;
    assign any_valid = stage0_q.valid || stage1_q.valid;

endmodule

// File: rtl/exec_int_sched.sv
// Issue and writeback scheduler for the integer execute stage: steers ALU/MUL
// ops to the datapath, DIV to the iterative divider, and tags in-order writeback.
module exec_int_sched
    import exec_int_sched_pkg::*;
#(
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_opcode,
    input  logic [2:0] in_funct3,
    input  logic [6:0] in_funct7,
    input  logic [4:0] in_rd,
    input  logic       flush,
    output logic       int_issue,
    input  logic       int_result_valid,
    output logic       div_start,
    output logic       div_abort,
    input  logic       div_done,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_sel,
    output logic       sched_error,
    output logic       busy
);

    localparam int               CNT_W        = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]       div_rd_q, div_rd_d;

    instr_class_e in_class;
    logic         accept;
    logic         div_hit;
    logic         div_timeout;
    logic         tag_pop_valid;
    logic [4:0]   tag_pop_rd;
    logic         tag_any_valid;

    assign in_class    = classify(in_opcode, in_funct3, in_funct7);
    assign accept      = in_valid && (state_q == ST_IDLE) && !flush;
    assign div_hit     = (state_q == ST_DIV_RUN) && div_done && !flush;
    assign div_timeout = (state_q == ST_DIV_RUN) && !div_done && !flush &&
                         (div_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            div_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_rd_q  <= div_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_rd_d  = div_rd_q;
        if (flush) begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (in_class == CLS_MUL)) begin
                        state_d = ST_MUL_GAP;
                    end else if (accept && (in_class == CLS_DIV)) begin
                        state_d   = ST_DIV_RUN;
                        div_rd_d  = in_rd;
                        div_cnt_d = '0;
                    end
                end
                ST_MUL_GAP: state_d = ST_IDLE;
                ST_DIV_RUN: begin
                    if (div_hit || div_timeout) begin
                        state_d = ST_IDLE;
                    end else begin
                        div_cnt_d = div_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Divider results can only land after the integer tags have drained, so the
    // two writeback sources never coincide.
    always_comb begin
        in_ready    = (state_q == ST_IDLE) && !flush;
        int_issue   = accept && (in_class != CLS_DIV);
        div_start   = accept && (in_class == CLS_DIV);
        div_abort   = div_timeout || (flush && (state_q == ST_DIV_RUN));
        sched_error = div_timeout;
        wb_valid    = div_hit || (tag_pop_valid && !flush);
        wb_sel      = div_hit;
        wb_rd       = 5'd0;
        if (div_hit) begin
            wb_rd = div_rd_q;
        end else if (tag_pop_valid && !flush) begin
            wb_rd = tag_pop_rd;
        end
        busy        = (state_q != ST_IDLE) || tag_any_valid;
    end

    exec_int_tag_pipe u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push_valid  (int_issue),
        .push_rd     (in_rd),
        .push_is_mul (in_class == CLS_MUL),
        .pop         (int_result_valid),
        .pop_valid   (tag_pop_valid),
        .pop_rd      (tag_pop_rd),
        .any_valid   (tag_any_valid)
    );

endmodule
